seg_scan: RTL
=============

Name: seg_scan

Overview:
- Parametrised successor to the single-digit hex-to-7-segment decoders.
- Drives DIGITS multiplexed common-anode digits from one shared active-low segment bus, with a programmable refresh divider.
- Double-buffered data load via valid/ready handshake; new data commits only at frame boundaries, so the display never tears.
- Sits between CPU/debug registers and the board's segment/anode pins.

Parameters:
- DIGITS, 8, number of digits scanned (2..16).
- CLK_DIV, 100000, clk cycles each digit stays lit (>=2).
- DIV_W, $clog2(CLK_DIV), divider counter width (derived).
- IDX_W, $clog2(DIGITS), digit index width (derived).

Ports:
- clk  input  1  system clock.
- resetn  input  1  asynchronous active-low reset.
- load_data  input  4*DIGITS  hex nibbles; nibble i drives digit i, digit 0 rightmost.
- load_dp  input  DIGITS  decimal point per digit, 1 = lit.
- load_en  input  DIGITS  digit enable, 0 = blanked.
- load_valid  input  1  load request.
- load_ready  output  1  pending buffer free.
- an  output  DIGITS  anode select, active-low one-hot.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low.
- frame_done  output  1  one-cycle pulse when the scan wraps to digit 0.

Behaviour:
- One clock; reset is asynchronous and active-low. All state clears on resetn=0 independent of clk.
- Reset values: div_cnt=0, idx=0, an=all 1, seg=7'h7F, dp=1, frame_done=0, load_ready=1. Shadow and pending data/dp/en = 0.
- Divider: div_cnt counts 0..CLK_DIV-1 and wraps. tick=1 when div_cnt==CLK_DIV-1.
- On tick: idx <= (idx==DIGITS-1) ? 0 : idx+1. frame_done <= 1 when idx wraps; otherwise frame_done=0.
- Outputs are registered from the current idx each cycle; an/seg/dp reflect the new idx exactly 1 cycle after the tick edge.
- Enabled digit: an = ~(1<<idx), seg = decode(shadow nibble idx), dp = ~shadow_dp[idx].
- Disabled digit: an, seg and dp all held at 1 for that slot; the slot still consumes CLK_DIV cycles, so other digits keep constant brightness.
- Decode table (active-low, gfedcba):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Handshake: load is accepted when load_valid && load_ready. On accept, data/dp/en are written to the pending buffer and pend_valid is set. load_ready = !pend_valid (registered state, not combinational from load_valid).
- Commit: on a tick with idx==DIGITS-1 and pend_valid=1, shadow <= pending and pend_valid is cleared. The newly committed data is first displayed on digit 0 of the next frame.
- Simultaneous commit and load_valid: load_ready is 0 that cycle, so there is no accept; the load is accepted on the following cycle.
- Shadow is never written outside a commit.
- Reset mid-frame or mid-handshake: pending data is discarded, idx returns to 0, and all digits blank until the first commit.

Optional Feature:
- SEG_SCAN_LZ_SUPPRESS_EN defined: a digit with nibble 0 is blanked (treated as disabled) when all higher-index enabled digits are also 0.
  - Digit 0 is never suppressed.
  - A digit whose dp bit is lit is never suppressed, and it stops suppression below it.
  - Suppression is evaluated on shadow data.
- Macro undefined: every enabled digit is displayed, leading zeros included.

Test Plan:
- Reset with DIGITS=4, CLK_DIV=4 -> an=4'hF, seg=7'h7F, dp=1, load_ready=1 while resetn=0 and for the first cycle after release.
- Load data=16'h1A3F, en=4'hF, dp=4'b0100; wait one frame -> each digit lit for 4 cycles in order:
  - an=E, seg=0E (F); an=D, seg=30 (3); an=B, seg=08 (A), dp=0; an=7, seg=79 (1).
  - frame_done pulses once per 16 cycles.
- Load during mid-frame -> load_ready=0 until the idx 3->0 tick; old data stays on digits 1..3; new data appears on digit 0 of the next frame; load_ready returns to 1.
- load_valid held high across the commit edge -> no accept on the commit cycle; exactly one accept on the next cycle; pend_valid=1 again.
- en=4'b1010 -> slots 0 and 2 show an=F, seg=7F for 4 cycles each; frame period unchanged at 16.
- With SEG_SCAN_LZ_SUPPRESS_EN, data=16'h0040 -> digits 3 and 2 blank, digit 1 shows 4 (19), digit 0 shows 0 (40). With dp[3]=1, digit 3 shows 0 and digit 2 is not suppressed.

Source files
------------

// File: rtl/seg_scan.sv
// seg_scan: multiplexed common-anode hex display driver.
// Scans DIGITS digits through one shared active-low segment bus. Each digit
// stays lit for CLK_DIV clock cycles. New display data is loaded through a
// valid/ready handshake into a pending buffer. The pending buffer moves into
// the shadow buffer only at a frame boundary, so a frame never mixes old and
// new data.
// Optional build macro: SEG_SCAN_LZ_SUPPRESS_EN enables leading-zero blanking.
module seg_scan #(
  parameter int DIGITS  = 8,
  parameter int CLK_DIV = 100000,
  parameter int DIV_W   = $clog2(CLK_DIV),
  parameter int IDX_W   = $clog2(DIGITS)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [4*DIGITS-1:0]   load_data,
  input  logic [DIGITS-1:0]     load_dp,
  input  logic [DIGITS-1:0]     load_en,
  input  logic                  load_valid,
  output logic                  load_ready,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_done
);

  logic [DIV_W-1:0]    div_cnt;
  logic [IDX_W-1:0]    idx;
  logic                tick;
  logic                last_digit;
  logic                accept;
  logic                commit;

  logic                pend_valid;
  logic [4*DIGITS-1:0] pend_data;
  logic [DIGITS-1:0]   pend_dp;
  logic [DIGITS-1:0]   pend_en;

  logic [4*DIGITS-1:0] shadow_data;
  logic [DIGITS-1:0]   shadow_dp;
  logic [DIGITS-1:0]   shadow_en;

  logic [DIGITS-1:0]   show;
  logic [3:0]          cur_nib;

  // Hex nibble to active-low {g,f,e,d,c,b,a} segment pattern
  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0: pat = 7'h40;
      4'h1: pat = 7'h79;
      4'h2: pat = 7'h24;
      4'h3: pat = 7'h30;
      4'h4: pat = 7'h19;
      4'h5: pat = 7'h12;
      4'h6: pat = 7'h02;
      4'h7: pat = 7'h78;
      4'h8: pat = 7'h00;
      4'h9: pat = 7'h10;
      4'hA: pat = 7'h08;
      4'hB: pat = 7'h03;
      4'hC: pat = 7'h46;
      4'hD: pat = 7'h21;
      4'hE: pat = 7'h06;
      default: pat = 7'h0E;
    endcase
    return pat;
  endfunction

  assign tick       = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign last_digit = (idx == IDX_W'(DIGITS - 1));
  assign load_ready = !pend_valid;
  assign accept     = load_valid && !pend_valid;
  assign commit     = tick && last_digit && pend_valid;
  assign cur_nib    = shadow_data[{idx, 2'b00} +: 4];

  // Refresh divider: one tick every CLK_DIV cycles advances the scan
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Digit index advances on each tick; frame_done flags the wrap to digit 0
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idx        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= tick && last_digit;
      if (tick) begin
        idx <= last_digit ? '0 : idx + 1'b1;
      end
    end
  end

  // Pending buffer: filled on handshake accept, released by a frame commit
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend_valid <= 1'b0;
      pend_data  <= '0;
      pend_dp    <= '0;
      pend_en    <= '0;
    end else if (accept) begin
      pend_valid <= 1'b1;
      pend_data  <= load_data;
      pend_dp    <= load_dp;
      pend_en    <= load_en;
    end else if (commit) begin
      pend_valid <= 1'b0;
    end
  end

  // Shadow buffer: only ever updated at the last-digit tick of a frame
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      shadow_data <= '0;
      shadow_dp   <= '0;
      shadow_en   <= '0;
    end else if (commit) begin
      shadow_data <= pend_data;
      shadow_dp   <= pend_dp;
      shadow_en   <= pend_en;
    end
  end

`ifdef SEG_SCAN_LZ_SUPPRESS_EN
  logic lz_leading;

  // Blank enabled zero digits above the first nonzero or dp-lit enabled digit
  always_comb begin
    show       = shadow_en;
    lz_leading = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (shadow_en[i]) begin
        if (lz_leading && (shadow_data[4*i +: 4] == 4'h0) && !shadow_dp[i]) begin
          show[i] = 1'b0;
        end else begin
          lz_leading = 1'b0;
        end
      end
    end
  end
`else
  assign show = shadow_en;
`endif

  // Registered pin drive for the current digit; hidden slots stay fully dark
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      an  <= '1;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else if (show[idx]) begin
      an  <= ~(DIGITS'(1) << idx);
      seg <= decode(cur_nib);
      dp  <= ~shadow_dp[idx];
    end else begin
      an  <= '1;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end
  end

endmodule
